// File: rtl/rt_frame_sequencer.sv
`timescale 1ns/1ps
// Raster-order frame sequencer: issues pixel coordinates to a ray tracer one at a time
// and collects the traced colours, tagged with start-of-frame/end-of-line, into an output FIFO.
//
// state  | meaning
// IDLE   | no frame in progress, FIFO empty, waiting for start
// ISSUE  | next pixel is issued once the FIFO has room for its result
// WAIT   | one pixel outstanding; timer runs down to a forced black result
// DRAIN  | every pixel traced; waiting for downstream to empty the FIFO
module rt_frame_sequencer #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FIFO_DEPTH = 4,
    parameter int RT_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [9:0]  rt_px_x,
    output logic [8:0]  rt_px_y,
    output logic        rt_px_valid,
    input  logic [7:0]  rt_r,
    input  logic [7:0]  rt_g,
    input  logic [7:0]  rt_b,
    input  logic        rt_valid,
    output logic [23:0] out_rgb,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = $clog2(RT_TIMEOUT + 1);

    localparam logic [9:0]    X_LAST   = 10'(H_RES - 1);
    localparam logic [8:0]    Y_LAST   = 9'(V_RES - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(RT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t        state;
    logic [9:0]    x;
    logic [8:0]    y;
    logic [TW-1:0] timer;

    // FIFO entry layout: {sof, eol, r, g, b}
    logic [25:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [25:0]   head;

    logic          abort_act;
    logic          fifo_full;
    logic          take;
    logic          tmo_hit;
    logic          push;
    logic          pop;
    logic          last_px;
    logic [25:0]   push_data;

    assign abort_act = abort && (state != S_IDLE);
    assign fifo_full = (count == DEPTH_C);
    assign take      = (state == S_WAIT) && (rt_valid || (timer == '0));
    assign tmo_hit   = (state == S_WAIT) && !rt_valid && (timer == '0);
    assign push      = take && !abort_act;
    assign pop       = out_valid && out_ready && !abort_act;
    assign last_px   = (x == X_LAST) && (y == Y_LAST);
    assign push_data = {(x == '0) && (y == '0), (x == X_LAST),
                        rt_valid ? {rt_r, rt_g, rt_b} : 24'h000000};

    assign head       = fifo_mem[rd_ptr];
    assign out_valid  = (count != '0);
    assign out_rgb    = out_valid ? head[23:0] : 24'h000000;
    assign out_sof    = out_valid && head[25];
    assign out_eol    = out_valid && head[24];
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DRAIN) && pop && (count == ONE_C);
    assign rt_px_x    = x;
    assign rt_px_y    = y;

    // Storage is not reset; entries are only visible through out_valid gating.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort_act) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            x           <= '0;
            y           <= '0;
            timer       <= '0;
            rt_px_valid <= 1'b0;
            timeout_err <= 1'b0;
        end else if (abort_act) begin
            state       <= S_IDLE;
            x           <= '0;
            y           <= '0;
            timer       <= '0;
            rt_px_valid <= 1'b0;
        end else begin
            rt_px_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_ISSUE;
                        x           <= '0;
                        y           <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (!fifo_full) begin
                        rt_px_valid <= 1'b1;
                        timer       <= TMR_LOAD;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (take) begin
                        if (tmo_hit) begin
                            timeout_err <= 1'b1;
                        end
                        if (last_px) begin
                            state <= S_DRAIN;
                            x     <= '0;
                            y     <= '0;
                        end else begin
                            state <= S_ISSUE;
                            if (x == X_LAST) begin
                                x <= '0;
                                y <= y + 1'b1;
                            end else begin
                                x <= x + 1'b1;
                            end
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if ((count == '0) || (pop && (count == ONE_C))) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rt_frame_sequencer.sv
`timescale 1ns/1ps
// Directed bench for rt_frame_sequencer on a 4x2 frame with a 3-cycle tracer model,
// an output collector, and checks for stall, timeout, abort, stray strobes and reset.
module tb_rt_frame_sequencer;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [9:0]  rt_px_x;
    logic [8:0]  rt_px_y;
    logic        rt_px_valid;
    logic [7:0]  rt_r = 8'h00;
    logic [7:0]  rt_g = 8'h00;
    logic [7:0]  rt_b = 8'h00;
    logic        rt_valid = 1'b0;
    logic [23:0] out_rgb;
    logic        out_sof;
    logic        out_eol;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;

    rt_frame_sequencer #(
        .H_RES(4), .V_RES(2), .FIFO_DEPTH(4), .RT_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rt_px_x(rt_px_x), .rt_px_y(rt_px_y), .rt_px_valid(rt_px_valid),
        .rt_r(rt_r), .rt_g(rt_g), .rt_b(rt_b), .rt_valid(rt_valid),
        .out_rgb(out_rgb), .out_sof(out_sof), .out_eol(out_eol),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [23:0] col(input int px, input int py);
        return {8'(px * 3 + 1), 8'(py * 5 + 2), 8'(px + py * 16 + 7)};
    endfunction

    // Tracer model: answers 3 cycles after the issue strobe unless the pixel is marked dropped.
    int drop_en = 0, drop_x = 0, drop_y = 0;
    int stray_cnt = 0, stray_seen = 0;
    int tr_pend = 0, tr_cnt = 0, tr_x = 0, tr_y = 0;

    always @(negedge clk) begin
        rt_valid = 1'b0;
        if (stray_cnt != stray_seen) begin
            stray_seen = stray_cnt;
            rt_valid = 1'b1;
            {rt_r, rt_g, rt_b} = 24'hABCDEF;
        end
        if (tr_pend != 0) begin
            tr_cnt--;
            if (tr_cnt == 0) begin
                tr_pend = 0;
                if (!(drop_en != 0 && tr_x == drop_x && tr_y == drop_y)) begin
                    rt_valid = 1'b1;
                    {rt_r, rt_g, rt_b} = col(tr_x, tr_y);
                end
            end
        end
        if (rt_px_valid) begin
            tr_pend = 1;
            tr_cnt  = 3;
            tr_x    = int'(rt_px_x);
            tr_y    = int'(rt_px_y);
        end
    end

    // Collector of issues, pops and frame_done pulses, sampled mid-cycle.
    logic [23:0] pop_rgb [128];
    logic        pop_sof [128];
    logic        pop_eol [128];
    int          iss_x [128];
    int          iss_y [128];
    int          iss_t [128];
    int n_pop = 0, n_iss = 0, n_done = 0, done_at = 0;

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (rt_px_valid && n_iss < 128) begin
                iss_x[n_iss] = int'(rt_px_x);
                iss_y[n_iss] = int'(rt_px_y);
                iss_t[n_iss] = cyc_cnt;
                n_iss++;
            end
            if (out_valid && out_ready && n_pop < 128) begin
                pop_rgb[n_pop] = out_rgb;
                pop_sof[n_pop] = out_sof;
                pop_eol[n_pop] = out_eol;
                n_pop++;
            end
            if (frame_done) begin
                n_done++;
                done_at = n_pop;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string t);
        chk({t, "_pxv"},  32'(rt_px_valid), 0);
        chk({t, "_ov"},   32'(out_valid),   0);
        chk({t, "_busy"}, 32'(busy),        0);
        chk({t, "_fd"},   32'(frame_done),  0);
        chk({t, "_tmo"},  32'(timeout_err), 0);
        chk({t, "_rgb"},  32'(out_rgb),     0);
        chk({t, "_sof"},  32'(out_sof),     0);
        chk({t, "_eol"},  32'(out_eol),     0);
        chk({t, "_x"},    32'(rt_px_x),     0);
        chk({t, "_y"},    32'(rt_px_y),     0);
    endtask

    task automatic check_frame(input string t, input int bp, input int bi, input int drop);
        for (int i = 0; i < 8; i++) begin
            int px;
            int py;
            px = i % 4;
            py = i / 4;
            chk($sformatf("%s_rgb%0d", t, i), 32'(pop_rgb[bp + i]),
                (i == drop) ? 32'h0 : 32'(col(px, py)));
            chk($sformatf("%s_sof%0d", t, i), 32'(pop_sof[bp + i]), (i == 0) ? 1 : 0);
            chk($sformatf("%s_eol%0d", t, i), 32'(pop_eol[bp + i]), (px == 3) ? 1 : 0);
            chk($sformatf("%s_ix%0d", t, i), iss_x[bi + i], px);
            chk($sformatf("%s_iy%0d", t, i), iss_y[bi + i], py);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bd, input string t);
        int k;
        k = 0;
        while (n_done == bd && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk({t, "_done_seen"}, (n_done != bd) ? 1 : 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bp, bi, bd, k, d;

        // Reset state
        repeat (2) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal frame, out_ready high
        out_ready = 1'b1;
        bp = n_pop; bi = n_iss; bd = n_done;
        pulse_start();
        wait_done(bd, "f1");
        chk("f1_pops", n_pop - bp, 8);
        chk("f1_iss", n_iss - bi, 8);
        chk("f1_ndone", n_done - bd, 1);
        chk("f1_done_at", done_at - bp, 8);
        chk("f1_rate", iss_t[bi + 1] - iss_t[bi], 5);
        chk("f1_rate_wrap", iss_t[bi + 4] - iss_t[bi + 3], 5);
        check_frame("f1", bp, bi, -1);
        chk("f1_idle", 32'(busy), 0);

        // Back-pressure: FIFO fills, issuing stalls, head holds
        out_ready = 1'b0;
        bp = n_pop; bi = n_iss; bd = n_done;
        pulse_start();
        repeat (60) @(negedge clk);
        chk("stall_iss", n_iss - bi, 4);
        chk("stall_pxv", 32'(rt_px_valid), 0);
        chk("stall_busy", 32'(busy), 1);
        chk("stall_head", 32'(out_rgb), 32'(col(0, 0)));
        chk("stall_sof", 32'(out_sof), 1);
        repeat (5) @(negedge clk);
        chk("stall_hold", 32'(out_rgb), 32'(col(0, 0)));
        chk("stall_pops", n_pop - bp, 0);
        out_ready = 1'b1;
        wait_done(bd, "f2");
        chk("f2_pops", n_pop - bp, 8);
        chk("f2_ndone", n_done - bd, 1);
        check_frame("f2", bp, bi, -1);

        // Tracer never answers pixel (1,0)
        drop_en = 1; drop_x = 1; drop_y = 0;
        bp = n_pop; bi = n_iss; bd = n_done;
        pulse_start();
        k = 0;
        while (!timeout_err && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_set", 32'(timeout_err), 1);
        d = cyc_cnt - iss_t[bi + 1];
        chk("tmo_lat", (d >= TMO && d <= TMO + 1) ? 1 : 0, 1);
        wait_done(bd, "f3");
        chk("f3_pops", n_pop - bp, 8);
        check_frame("f3", bp, bi, 1);
        chk("tmo_sticky", 32'(timeout_err), 1);
        drop_en = 0;

        // Abort during WAIT of pixel (2,1) with entries queued
        out_ready = 1'b0;
        bp = n_pop; bi = n_iss; bd = n_done;
        pulse_start();
        chk("start_clr_tmo", 32'(timeout_err), 0);
        repeat (40) @(negedge clk);
        chk("ab_full", n_iss - bi, 4);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        k = 0;
        while (n_iss - bi < 7 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("ab_iss", n_iss - bi, 7);
        chk("ab_pre_valid", 32'(out_valid), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_flush", 32'(out_valid), 0);
        chk("ab_x", 32'(rt_px_x), 0);
        chk("ab_y", 32'(rt_px_y), 0);
        repeat (10) @(negedge clk);
        chk("ab_late", 32'(out_valid), 0);
        chk("ab_nodone", n_done - bd, 0);
        chk("ab_pops", n_pop - bp, 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("ab_pop%0d", i), 32'(pop_rgb[bp + i]), 32'(col(i, 0)));
        out_ready = 1'b1;
        bp = n_pop; bi = n_iss; bd = n_done;
        pulse_start();
        wait_done(bd, "rs");
        chk("rs_pops", n_pop - bp, 8);
        check_frame("rs", bp, bi, -1);

        // Stray rt_valid in IDLE, then start pulsed while busy
        bp = n_pop;
        stray_cnt++;
        repeat (5) @(negedge clk);
        chk("stray_valid", 32'(out_valid), 0);
        chk("stray_pops", n_pop - bp, 0);
        chk("stray_busy", 32'(busy), 0);
        bi = n_iss; bd = n_done;
        pulse_start();
        repeat (7) @(negedge clk);
        pulse_start();
        wait_done(bd, "f5");
        chk("f5_pops", n_pop - bp, 8);
        chk("f5_iss", n_iss - bi, 8);
        chk("f5_ndone", n_done - bd, 1);
        check_frame("f5", bp, bi, -1);

        // Asynchronous reset mid-frame with three entries queued
        out_ready = 1'b0;
        bi = n_iss;
        pulse_start();
        k = 0;
        while (n_iss - bi < 4 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("ar_pre_valid", 32'(out_valid), 1);
        chk("ar_pre_sof", 32'(out_sof), 1);
        rst_n = 1'b0;
        #1;
        check_zero("arst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_noiss", n_iss - bi, 4);
        bp = n_pop; bi = n_iss; bd = n_done;
        pulse_start();
        wait_done(bd, "rec");
        chk("rec_pops", n_pop - bp, 8);
        check_frame("rec", bp, bi, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
